// File: rtl/spi_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_capture
// Brief    : Multi-channel serial ADC front end. Drives a shared SCLK/nCS,
//            captures CHANNELS sdata lines MSB first and presents one packed
//            word per frame on a valid/ready port. Single-shot or free-running.
// Revision : 1.0 - initial release
// ============================================================================
module spi_adc_capture #(
    parameter int CHANNELS      = 2,
    parameter int FRAME_W       = 16,
    parameter int DATA_W        = 12,
    parameter int CLK_DIV       = 4,
    parameter int CS_IDLE       = 2,
    parameter int SAMPLE_PERIOD = 400
) (
    input  logic                         clk_sclk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cont_en,
    output logic                         busy,
    output logic                         done,
    output logic                         p_valid,
    input  logic                         p_ready,
    output logic [CHANNELS*DATA_W-1:0]   p_data,
    output logic                         overrun,
    input  logic [CHANNELS-1:0]          adc_sdata,
    output logic                         adc_sclk,
    output logic                         adc_ncs
);

    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int HOLD_CYC = CS_IDLE * 2 * CLK_DIV;
    localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
    localparam int PER_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  C_DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0]  C_BIT_ONE   = BIT_W'(1);
    localparam logic [HOLD_W-1:0] C_HOLD_LOAD = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] C_HOLD_ONE  = HOLD_W'(1);
    localparam logic [PER_W-1:0]  C_PER_LOAD  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [PER_W-1:0]  C_PER_ONE   = PER_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DIV_W-1:0]    r_div, w_div_nxt;
    logic                r_phase, w_phase_nxt;
    logic [BIT_W-1:0]    r_bit, w_bit_nxt;
    logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
    logic [PER_W-1:0]    r_period, w_period_nxt;
    logic                r_done, w_done_nxt;
    logic                w_shift_en;
    logic                w_div_last;
    logic                r_sclk, r_ncs;
    logic                r_p_valid, r_overrun;
    logic [CHANNELS*DATA_W-1:0] r_p_data, w_frame;
    logic [DATA_W-1:0]   r_shift [CHANNELS];

    always_ff @(posedge clk_sclk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_phase  <= 1'b0;
            r_bit    <= '0;
            r_hold   <= '0;
            r_period <= '0;
            r_done   <= 1'b0;
            r_sclk   <= 1'b1;
            r_ncs    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_phase  <= w_phase_nxt;
            r_bit    <= w_bit_nxt;
            r_hold   <= w_hold_nxt;
            r_period <= w_period_nxt;
            r_done   <= w_done_nxt;
            // Pins are registered from the next state so they never glitch
            r_sclk   <= !((w_state_nxt == ST_SHIFT) && !w_phase_nxt);
            r_ncs    <= !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT));
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_phase_nxt  = r_phase;
        w_bit_nxt    = r_bit;
        w_hold_nxt   = r_hold;
        w_period_nxt = (r_period != '0) ? (r_period - C_PER_ONE) : r_period;
        w_done_nxt   = 1'b0;
        w_shift_en   = 1'b0;
        w_div_last   = (r_div == C_DIV_LAST);
        case (r_state)
            ST_IDLE: begin
                if (start || cont_en) begin
                    w_state_nxt  = ST_SETUP;
                    w_div_nxt    = '0;
                    w_period_nxt = C_PER_LOAD;
                end
            end
            ST_SETUP: begin
                if (w_div_last) begin
                    w_state_nxt = ST_SHIFT;
                    w_div_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = '0;
                end else begin
                    w_div_nxt = r_div + C_DIV_ONE;
                end
            end
            ST_SHIFT: begin
                if (!w_div_last) begin
                    w_div_nxt = r_div + C_DIV_ONE;
                end else begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        // End of low phase: this edge is the SCLK rise
                        w_phase_nxt = 1'b1;
                        w_shift_en  = 1'b1;
                    end else if (r_bit == C_BIT_LAST) begin
                        w_state_nxt = ST_HOLDOFF;
                        w_hold_nxt  = C_HOLD_LOAD;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        w_bit_nxt   = r_bit + C_BIT_ONE;
                    end
                end
            end
            ST_HOLDOFF: begin
                // The first holdoff cycle is the done cycle; CS_IDLE periods follow
                if (r_hold != '0) begin
                    w_hold_nxt = r_hold - C_HOLD_ONE;
                end else if (!cont_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_period == '0) begin
                    w_state_nxt  = ST_SETUP;
                    w_div_nxt    = '0;
                    w_period_nxt = C_PER_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sclk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shift[k] <= '0;
            end
        end else if (w_shift_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shift[k] <= DATA_W'({r_shift[k], adc_sdata[k]});
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            assign w_frame[g*DATA_W +: DATA_W] = r_shift[g];
        end
    endgenerate

    always_ff @(posedge clk_sclk or negedge rst) begin
        if (!rst) begin
            r_p_data  <= '0;
            r_p_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_done) begin
            r_p_data  <= w_frame;
            r_p_valid <= 1'b1;
            if (r_p_valid && !p_ready) begin
                r_overrun <= 1'b1;
            end else if (r_p_valid && p_ready) begin
                r_overrun <= 1'b0;
            end
        end else if (r_p_valid && p_ready) begin
            r_p_valid <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign p_valid  = r_p_valid;
    assign p_data   = r_p_data;
    assign overrun  = r_overrun;
    assign adc_sclk = r_sclk;
    assign adc_ncs  = r_ncs;

endmodule
`default_nettype wire
